// File: rtl/dual_port_ram_if.sv
// Bus bundle for the true dual-port RAM: two independent read/write ports
// plus the registered same-address write-collision flag.
interface dual_port_ram_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] din_b;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  we_a;
    logic                  we_b;
    logic [DATA_WIDTH-1:0] dout_a;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  collision_detected;

    modport master (
        output din_a, din_b, addr_a, addr_b, we_a, we_b,
        input  dout_a, dout_b, collision_detected
    );

    modport slave (
        input  din_a, din_b, addr_a, addr_b, we_a, we_b,
        output dout_a, dout_b, collision_detected
    );
endinterface

// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM on one clock. Same-port accesses are
// write-first, cross-port accesses are read-before-write, and port A wins
// a same-address double write.
module dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    dual_port_ram_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] dout_a_q;
    logic [DATA_WIDTH-1:0] dout_a_d;
    logic [DATA_WIDTH-1:0] dout_b_q;
    logic [DATA_WIDTH-1:0] dout_b_d;
    logic                  collision_q;
    logic                  collision_d;
    logic                  wr_a_en;
    logic                  wr_b_en;

    // Next read data and write enables; B's write is dropped when A hits the same word.
    always_comb begin
        collision_d = 1'b0;
        wr_a_en     = 1'b0;
        wr_b_en     = 1'b0;
        dout_a_d    = mem_q[bus.addr_a];
        dout_b_d    = mem_q[bus.addr_b];

        collision_d = bus.we_a && bus.we_b && (bus.addr_a == bus.addr_b);
        wr_a_en     = bus.we_a;
        wr_b_en     = bus.we_b && !collision_d;

        if (bus.we_a) begin
            dout_a_d = bus.din_a;
        end
        if (bus.we_b) begin
            dout_b_d = collision_d ? bus.din_a : bus.din_b;
        end
    end

    // Storage and output registers; reset clears every word and blocks writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            collision_q <= 1'b0;
        end else begin
            if (wr_a_en) begin
                mem_q[bus.addr_a] <= bus.din_a;
            end
            if (wr_b_en) begin
                mem_q[bus.addr_b] <= bus.din_b;
            end
            dout_a_q    <= dout_a_d;
            dout_b_q    <= dout_b_d;
            collision_q <= collision_d;
        end
    end

    assign bus.dout_a             = dout_a_q;
    assign bus.dout_b             = dout_b_q;
    assign bus.collision_detected = collision_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: the driver predicts each edge's
// outputs from a reference memory and the monitor compares after the edge.
module tb_dual_port_ram;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] dout_a;
        logic [DW-1:0] dout_b;
        logic          coll;
    } exp_t;

    logic clk;
    logic rst;

    dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t          sb_q [$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            n_checks = 0;
    int            n_pass   = 0;
    bit            drv_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the predicted outputs of that edge.
    task automatic step(input logic r,
                        input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        exp_t e;
        rst        = r;
        bus.we_a   = wa;
        bus.addr_a = aa;
        bus.din_a  = da;
        bus.we_b   = wb;
        bus.addr_b = ab;
        bus.din_b  = db;
        if (r) begin
            e.dout_a = '0;
            e.dout_b = '0;
            e.coll   = 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        end else begin
            e.coll   = wa && wb && (aa == ab);
            e.dout_a = wa ? da : ref_mem[aa];
            if (!wb)         e.dout_b = ref_mem[ab];
            else if (e.coll) e.dout_b = da;
            else             e.dout_b = db;
            if (wb && !e.coll) ref_mem[ab] = db;
            if (wa)            ref_mem[aa] = da;
        end
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rd(input logic [AW-1:0] aa, input logic [AW-1:0] ab);
        step(1'b0, 1'b0, aa, 8'h00, 1'b0, ab, 8'h00);
    endtask

    // Monitor: compare one scoreboard entry shortly after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("dout_a", 32'(bus.dout_a), 32'(e.dout_a));
                check_eq("dout_b", 32'(bus.dout_b), 32'(e.dout_b));
                check_eq("collision_detected", 32'(bus.collision_detected), 32'(e.coll));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        bus.we_a   = 1'b0;
        bus.we_b   = 1'b0;
        bus.addr_a = '0;
        bus.addr_b = '0;
        bus.din_a  = '0;
        bus.din_b  = '0;

        // Reset after arbitrary writes, then every word reads back zero.
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, AW'(i), DW'($urandom), 1'b1, AW'(i + 8), DW'($urandom));
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 8; i++) rd(AW'(i), AW'(i + 8));

        // Port A write (write-first), port B write, simultaneous reads.
        step(1'b0, 1'b1, 4'd1, 8'hAA, 1'b0, 4'd0, 8'h00);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 8'h55);
        rd(4'd1, 4'd2);

        // Cross-port same address: B sees the old value, then the new one.
        step(1'b0, 1'b1, 4'd2, 8'h77, 1'b0, 4'd2, 8'h00);
        rd(4'd1, 4'd2);

        // Collision: A wins, flag for one cycle.
        step(1'b0, 1'b1, 4'd3, 8'hF0, 1'b1, 4'd3, 8'h0F);
        rd(4'd3, 4'd3);

        // Back-to-back collisions keep the flag high.
        step(1'b0, 1'b1, 4'd6, 8'h12, 1'b1, 4'd6, 8'h34);
        step(1'b0, 1'b1, 4'd7, 8'h56, 1'b1, 4'd7, 8'h78);
        rd(4'd6, 4'd7);

        // Parallel writes to different addresses, then readback.
        step(1'b0, 1'b1, 4'd4, 8'h11, 1'b1, 4'd5, 8'h22);
        rd(4'd4, 4'd5);

        // B writes while A reads the same address: A gets old data.
        step(1'b0, 1'b0, 4'd5, 8'h00, 1'b1, 4'd5, 8'h99);
        rd(4'd5, 4'd5);

        // Address extremes.
        step(1'b0, 1'b1, 4'd15, 8'hFF, 1'b1, 4'd0, 8'h01);
        rd(4'd0, 4'd15);

        // Reset mid-operation discards the write of that cycle.
        step(1'b1, 1'b1, 4'd9, 8'hC3, 1'b1, 4'd10, 8'h3C);
        rd(4'd9, 4'd10);
        rd(4'd1, 4'd3);

        // Random traffic over a narrow address window to provoke collisions.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom), AW'($urandom_range(0, 3)), DW'($urandom),
                 1'($urandom), AW'($urandom_range(0, 3)), DW'($urandom));
        end
        for (int i = 0; i < int'(DEPTH); i++) rd(AW'(i), AW'(DEPTH - 1 - i));

        @(negedge clk);
        @(negedge clk);
        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        drv_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop if the driver never completes.
    initial begin
        #200000;
        if (!drv_done) begin
            $display("FAIL timeout: driver did not complete, got %0d checks, expected completion", n_checks);
            $fatal(1, "timeout");
        end
    end

endmodule
